pipe_adder_tree_acc: RTL and testbench
======================================

// Module: pipe_adder_tree_acc
// PURPOSE
//  Parametrised, pipelined N_IN-input adder tree with an optional cross-beat accumulator.
//  Sums one vector of N_IN operands per accepted beat.
//  Supports valid/ready flow control on both sides.
//  Sits after the MLU multiplier array to reduce partial products and accumulate dot products.
// PARAMETERS
//  WIDTH   32                         operand width (bits)
//  N_IN    16                         operand count; power of 2, >= 2
//  ACC_W   WIDTH+$clog2(N_IN)+8       result/accumulator width; must be >= WIDTH+$clog2(N_IN)
//  SIGNED  1                          1: two's-complement operands and results; 0: unsigned
// PORTS
//  clk        in   1              clock, rising edge
//  rst_n      in   1              asynchronous reset, active-low
//  in_valid   in   1              input beat valid
//  in_ready   out  1              block can accept a beat
//  in_data    in   WIDTH x N_IN   operands, unpacked array [N_IN-1:0]
//  in_first   in   1              first beat of an accumulation packet
//  in_last    in   1              last beat of an accumulation packet
//  acc_mode   in   1              0: one result per beat; 1: accumulate beats from first to last
//  out_valid  out  1              result valid
//  out_ready  in   1              downstream accepts the result
//  out_data   out  ACC_W          result
//  out_ovf    out  1              overflow flag for this result; sticky within a packet
// BEHAVIOUR
//  Pipeline structure
//  - L = $clog2(N_IN) tree levels, each registered, then 1 accumulator stage.
//  - Latency is L+1 cycles from acceptance to out_valid when there is no stall (default: 5).
//  - Operands are sign-extended (SIGNED=1) or zero-extended to ACC_W before level 0, so the tree itself can never overflow.
//  Flow control
//  - Global advance: en = !out_valid || out_ready. in_ready = en, combinational.
//  - Bubbles are not compressed.
//  - A beat is accepted when in_valid && in_ready.
//  - in_first, in_last and acc_mode are sampled on acceptance and travel with the data.
//  - One valid bit per stage. When en=0 every stage register holds.
//  - out_data and out_ovf must stay stable while out_valid && !out_ready.
//  Accumulator FSM: states ACC_IDLE, ACC_BUSY; advances only when en and the last tree stage is valid.
//  - acc_mode=0: out_data = tree sum, out_ovf = 0, out_valid = 1. FSM state is unchanged.
//  - acc_mode=1, IDLE or in_first:
//      - acc = sum, ovf = 0.
//      - If in_last: emit acc and stay IDLE. Otherwise go to BUSY with no output.
//      - In IDLE a beat without in_first is treated as first.
//  - acc_mode=1, BUSY and !in_first:
//      - acc = acc + sum, computed at ACC_W width.
//      - ovf |= signed overflow (SIGNED=1) or carry-out (SIGNED=0).
//      - If in_last: emit, go to IDLE. Otherwise no output.
//  - in_first during BUSY discards the open packet and restarts with this beat.
//  - acc_mode=0 beats interleaved with an open packet pass through and do not disturb acc.
//  - On overflow out_data holds the wrapped value.
//  Reset
//  - Asynchronous assertion clears all stage valid bits, stage registers, acc, out_data (0), out_valid (0) and out_ovf (0).
//  - FSM returns to IDLE.
//  - In-flight beats are dropped. There is no output for a packet interrupted by reset.
//  - While rst_n=0, in_ready reads 1 (en with out_valid=0); nothing is captured.
// TESTING
//  1. Defaults, acc_mode=0, in_data[i]=i+1 (1..16), single beat -> out_valid after 5 cycles, out_data=136, out_ovf=0.
//  2. SIGNED=1, all operands 32'hFFFF_FFFF -> out_data=-16 (sign-extended to ACC_W); with SIGNED=0 -> 16*(2^32-1).
//  3. acc_mode=1, three beats of all-1 operands (first on beat 0, last on beat 2) -> exactly one output, out_data=48; no out_valid for beats 0-1.
//  4. 20 back-to-back acc_mode=0 beats with values k=0..19, out_ready=0 for cycles 3-12
//     -> in_ready low during stall, no loss or duplicates, outputs 16*k in order, out_data stable while stalled.
//  5. ACC_W=36, acc_mode=1, 2 beats of all 32'h7FFF_FFFF -> out_ovf=1, out_data = wrapped 36-bit sum.
//     A next packet with in_first -> out_ovf=0.
//  6. rst_n pulled low mid-packet (after beat 1 of 3) -> all outputs 0 within the reset.
//     New packet of 2 beats of all-2 operands -> out_data=64, no residue from the old packet.

Source files
------------

// File: rtl/pipe_adder_tree_acc.sv
// Pipelined N_IN-input adder tree followed by a packet accumulator stage.
// One global advance enable stalls every stage together when the output is blocked.
module pipe_adder_tree_acc #(
  parameter int WIDTH  = 32,
  parameter int N_IN   = 16,
  parameter int ACC_W  = WIDTH + $clog2(N_IN) + 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data [N_IN-1:0],
  input  logic             in_first,
  input  logic             in_last,
  input  logic             acc_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf
);

  // state    | meaning
  // ACC_IDLE | no packet open; next acc_mode=1 beat starts one
  // ACC_BUSY | packet open; acc holds the running sum
  typedef enum logic {ACC_IDLE, ACC_BUSY} acc_state_t;

  localparam int L = $clog2(N_IN);

  // Tree nodes stored flat, leaf-side level first; the root is the last entry.
  function automatic int lvl_base(int k);
    return N_IN - (N_IN >> k);
  endfunction

  logic             en;
  logic [ACC_W-1:0] ext     [N_IN];
  logic [ACC_W-1:0] node_q  [N_IN-1];
  logic [L-1:0]     vld_q, first_q, last_q, mode_q;
  logic [ACC_W-1:0] tree_sum;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign tree_sum = node_q[N_IN-2];

  always_comb begin
    for (int i = 0; i < N_IN; i++)
      ext[i] = {{(ACC_W-WIDTH){SIGNED && in_data[i][WIDTH-1]}}, in_data[i]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN-1; i++) node_q[i] <= '0;
      vld_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
      mode_q  <= '0;
    end else if (en) begin
      for (int j = 0; j < N_IN/2; j++)
        node_q[j] <= ext[2*j] + ext[2*j+1];
      for (int k = 1; k < L; k++)
        for (int j = 0; j < (N_IN >> (k+1)); j++)
          node_q[lvl_base(k)+j] <= node_q[lvl_base(k-1)+2*j] + node_q[lvl_base(k-1)+2*j+1];
      vld_q[0]   <= in_valid;
      first_q[0] <= in_first;
      last_q[0]  <= in_last;
      mode_q[0]  <= acc_mode;
      for (int k = 1; k < L; k++) begin
        vld_q[k]   <= vld_q[k-1];
        first_q[k] <= first_q[k-1];
        last_q[k]  <= last_q[k-1];
        mode_q[k]  <= mode_q[k-1];
      end
    end
  end

  acc_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_sum, out_data_d;
  logic [ACC_W:0]   acc_wide;
  logic             acc_ovf_q, acc_ovf_d, add_ovf, out_valid_d, out_ovf_d;

  assign acc_wide = {1'b0, acc_q} + {1'b0, tree_sum};
  assign acc_sum  = acc_wide[ACC_W-1:0];
  // Signed: operands agree in sign but the result does not. Unsigned: carry-out.
  assign add_ovf  = SIGNED ? ((acc_q[ACC_W-1] == tree_sum[ACC_W-1]) &&
                              (acc_sum[ACC_W-1] != acc_q[ACC_W-1]))
                           : acc_wide[ACC_W];

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    acc_ovf_d   = acc_ovf_q;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_ovf_d   = out_ovf;
    if (en) begin
      out_valid_d = 1'b0;
      if (vld_q[L-1]) begin
        if (!mode_q[L-1]) begin
          out_valid_d = 1'b1;
          out_data_d  = tree_sum;
          out_ovf_d   = 1'b0;
        end else if (state_q == ACC_IDLE || first_q[L-1]) begin
          acc_d     = tree_sum;
          acc_ovf_d = 1'b0;
          if (last_q[L-1]) begin
            out_valid_d = 1'b1;
            out_data_d  = tree_sum;
            out_ovf_d   = 1'b0;
            state_d     = ACC_IDLE;
          end else begin
            state_d = ACC_BUSY;
          end
        end else begin
          acc_d     = acc_sum;
          acc_ovf_d = acc_ovf_q | add_ovf;
          if (last_q[L-1]) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_sum;
            out_ovf_d   = acc_ovf_q | add_ovf;
            state_d     = ACC_IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACC_IDLE;
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      acc_ovf_q <= acc_ovf_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_ovf   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_pipe_adder_tree_acc.sv
// Scoreboard bench: three configurations (signed/44, unsigned/44, signed/36) share one
// stimulus stream; an arithmetic packet model predicts every emitted result.
module tb_pipe_adder_tree_acc;

  typedef logic signed [127:0] wide_t;
  typedef struct packed {
    logic [43:0] d0;
    logic [43:0] d1;
    logic [35:0] d2;
    logic        o0, o1, o2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, acc_mode = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_data [15:0];
  logic        rdy0, rdy1, rdy2, v0, v1, v2, o0, o1, o2;
  logic [43:0] d0, d1;
  logic [35:0] d2;

  int passed = 0, total = 0;
  exp_t exp_q[$];
  int   cfg_w [3] = '{44, 44, 36};
  bit   cfg_s [3] = '{1'b1, 1'b0, 1'b1};
  bit   m_open [3];
  wide_t m_acc [3];
  bit   m_ovf [3];
  bit   hold_pend = 1'b0;
  logic [43:0] hold_d;
  logic hold_o;

  always #5 clk = ~clk;

  pipe_adder_tree_acc u_sgn (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .in_first(in_first), .in_last(in_last), .acc_mode(acc_mode),
    .out_valid(v0), .out_ready(out_ready), .out_data(d0), .out_ovf(o0));
  pipe_adder_tree_acc #(.SIGNED(1'b0)) u_uns (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(rdy1), .in_data(in_data), .in_first(in_first), .in_last(in_last),
    .acc_mode(acc_mode), .out_valid(v1), .out_ready(out_ready), .out_data(d1), .out_ovf(o1));
  pipe_adder_tree_acc #(.ACC_W(36)) u_a36 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(rdy2), .in_data(in_data), .in_first(in_first), .in_last(in_last),
    .acc_mode(acc_mode), .out_valid(v2), .out_ready(out_ready), .out_data(d2), .out_ovf(o2));

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  function automatic wide_t wrapv(wide_t v, int w, bit sg);
    wide_t m;
    m = v & ((wide_t'(1) << w) - 1);
    if (sg && m[w-1]) m = m - (wide_t'(1) << w);
    return m;
  endfunction

  task automatic model_accept(bit first, bit last, bit mode);
    wide_t s, t;
    wide_t res [3];
    bit    ov [3];
    bit    emit;
    exp_t  e;
    emit = 1'b0;
    for (int c = 0; c < 3; c++) begin
      s = 0;
      for (int i = 0; i < 16; i++)
        s += cfg_s[c] ? wide_t'({{96{in_data[i][31]}}, in_data[i]}) : wide_t'({96'd0, in_data[i]});
      res[c] = s; ov[c] = 1'b0;
      if (!mode) begin
        emit = 1'b1;
      end else if (!m_open[c] || first) begin
        m_acc[c] = s; m_ovf[c] = 1'b0; m_open[c] = !last;
        emit = last;
      end else begin
        t = m_acc[c] + s;
        if (wrapv(t, cfg_w[c], cfg_s[c]) != t) m_ovf[c] = 1'b1;
        m_acc[c] = wrapv(t, cfg_w[c], cfg_s[c]);
        res[c] = m_acc[c]; ov[c] = m_ovf[c];
        m_open[c] = !last;
        emit = last;
      end
    end
    if (emit) begin
      e.d0 = res[0][43:0]; e.d1 = res[1][43:0]; e.d2 = res[2][35:0];
      e.o0 = ov[0]; e.o1 = ov[1]; e.o2 = ov[2];
      exp_q.push_back(e);
    end
  endtask

  // kind 0: all operands v; 1: operand i = i+1; 2: random
  task automatic send(int kind, logic [31:0] v, bit first, bit last, bit mode);
    int guard = 0;
    @(negedge clk);
    for (int i = 0; i < 16; i++)
      in_data[i] = (kind == 0) ? v : (kind == 1) ? 32'(i + 1) : $urandom();
    in_first = first; in_last = last; acc_mode = mode; in_valid = 1'b1;
    #1;
    while (!rdy0 && guard < 1000) begin @(negedge clk); #1; guard++; end
    chk("in_ready_timeout", {63'd0, rdy0}, 64'd1);
    if (rdy0) model_accept(first, last, mode);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (8) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_valid"}, {61'd0, v0, v1, v2}, 64'd0);
    chk({tag, "_data0"}, 64'(d0), 64'd0);
    chk({tag, "_data2"}, 64'(d2), 64'd0);
    chk({tag, "_ovf"}, {61'd0, o0, o1, o2}, 64'd0);
    chk({tag, "_in_ready"}, {61'd0, rdy0, rdy1, rdy2}, 64'd7);
  endtask

  // Monitor: output transfers when out_valid && out_ready at the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          chk("stall_valid_held", {63'd0, v0}, 64'd1);
          chk("stall_data_stable", 64'(d0), 64'(hold_d));
          chk("stall_ovf_stable", {63'd0, o0}, {63'd0, hold_o});
        end
        hold_pend = 1'b0;
        if (v0 || v1 || v2) begin
          chk("cfg_valid_agree", {62'd0, v1, v2}, {62'd0, v0, v0});
          if (!out_ready) begin
            chk("in_ready_stall", {61'd0, rdy0, rdy1, rdy2}, 64'd0);
            hold_pend = 1'b1; hold_d = d0; hold_o = o0;
          end else if (exp_q.size() == 0) begin
            chk("unexpected_out", {61'd0, v0, v1, v2}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("sum_signed", 64'(d0), 64'(e.d0));
            chk("ovf_signed", {63'd0, o0}, {63'd0, e.o0});
            chk("sum_unsigned", 64'(d1), 64'(e.d1));
            chk("ovf_unsigned", {63'd0, o1}, {63'd0, e.o1});
            chk("sum_w36", 64'(d2), 64'(e.d2));
            chk("ovf_w36", {63'd0, o2}, {63'd0, e.o2});
          end
        end
      end
    end
  end

  initial begin
    int cnt;
    bit done;
    for (int i = 0; i < 16; i++) in_data[i] = '0;
    repeat (3) @(negedge clk);
    #2 chk_reset_outputs("reset_init");
    @(negedge clk) rst_n = 1'b1;

    // single beat, operands 1..16, latency in cycles from the accepting edge
    send(1, 32'd0, 1'b0, 1'b0, 1'b0);
    idle();
    cnt = 1;
    while (!v0 && cnt < 20) begin @(negedge clk); #3; cnt++; end
    chk("latency", 64'(cnt), 64'd5);
    drain();

    send(0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    idle(); drain();

    // three-beat packet of ones; IDLE beat without first counts as first
    send(0, 32'd1, 1'b1, 1'b0, 1'b1);
    send(0, 32'd1, 1'b0, 1'b0, 1'b1);
    send(0, 32'd1, 1'b0, 1'b1, 1'b1);
    send(0, 32'd3, 1'b0, 1'b1, 1'b1);
    idle(); drain();

    // back-to-back with a 10-cycle downstream stall
    fork
      begin
        for (int k = 0; k < 20; k++) send(0, 32'(k), 1'b0, 1'b0, 1'b0);
        idle();
      end
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        repeat (10) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // overflow at 36 bits, then a fresh packet clears the flag; interleaved pass-through beat
    send(0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);
    send(0, 32'd9, 1'b0, 1'b0, 1'b0);
    send(0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
    send(0, 32'd5, 1'b1, 1'b0, 1'b1);
    send(0, 32'd6, 1'b1, 1'b1, 1'b1);
    idle(); drain();

    // reset mid-packet
    send(0, 32'd7, 1'b1, 1'b0, 1'b1);
    send(0, 32'd7, 1'b0, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) m_open[c] = 1'b0;
    exp_q.delete();
    #2 chk_reset_outputs("reset_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(0, 32'd2, 1'b0, 1'b0, 1'b1);
    send(0, 32'd2, 1'b0, 1'b1, 1'b1);
    idle(); drain();

    // randomized traffic with random backpressure and gaps
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          if ($urandom_range(0, 4) == 0) idle();
          send($urandom_range(0, 5) == 0 ? 0 : 2, $urandom(),
               $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
        end
        idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
